// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall vector, flush and held PC redirect control; PIPE_CTRL_PERF_CNT_EN adds perf counters
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        ex_branch_valid,
  input  logic        ex_prdt_taken,
  input  logic        ex_real_taken,
  input  logic [31:0] ex_branch_target,
  input  logic [31:0] ex_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);
  localparam logic [1:0] IDLE = 2'd0, FLUSH = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic req_if, req_id, mispredict;
  logic [31:0] target;
  assign flush = state == FLUSH;
  assign redirect_valid = state != IDLE;
  assign req_if = stallreq_if & ~flush;
  assign req_id = stallreq_id & ~flush;
  always_comb begin
    stall = rst ? 6'b000000 : stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
            req_id ? 6'b000111 : req_if ? 6'b000011 : 6'b000000;
  end
  assign mispredict = ex_branch_valid & (ex_prdt_taken != ex_real_taken) & ~stall[3] & (state == IDLE);
  assign target = ex_real_taken ? ex_branch_target : ex_pc + 32'd4;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      redirect_pc <= 32'd0;
    end else begin
      state <= state == IDLE ? (mispredict ? FLUSH : IDLE) : (stall[0] ? HOLD : IDLE);
      if (mispredict) redirect_pc <= target;
    end
  end
`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, stall[0]};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, flush};
    end
  end
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with a per-cycle expectation queue and a redirect scoreboard
module tb_pipe_ctrl;
  logic clk = 0;
  logic rst = 1;
  logic stallreq_if = 0, stallreq_id = 0, stallreq_ex = 0, stallreq_mem = 0;
  logic ex_branch_valid = 0, ex_prdt_taken = 0, ex_real_taken = 0;
  logic [31:0] ex_branch_target = 0, ex_pc = 0;
  logic [5:0] stall;
  logic flush, redirect_valid;
  logic [31:0] redirect_pc, perf_stall_cnt, perf_flush_cnt;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .ex_branch_valid(ex_branch_valid), .ex_prdt_taken(ex_prdt_taken),
    .ex_real_taken(ex_real_taken), .ex_branch_target(ex_branch_target), .ex_pc(ex_pc),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [5:0] stall;
    logic       flush;
    logic       rv;
  } exp_t;

  exp_t q[$];
  logic [31:0] rq[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_stall = 0, m_flush = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", {26'd0, stall}, {26'd0, e.stall});
      chk("flush", {31'd0, flush}, {31'd0, e.flush});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
      chk("perf_stall_cnt", perf_stall_cnt, PERF ? m_stall : 32'd0);
      chk("perf_flush_cnt", perf_flush_cnt, PERF ? m_flush : 32'd0);
      m_stall = e.rst ? 32'd0 : m_stall + {31'd0, e.stall[0]};
      m_flush = e.rst ? 32'd0 : m_flush + {31'd0, e.flush};
    end
    if (redirect_valid === 1'b1 && stall[0] === 1'b0 && !rst) begin
      if (rq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL redirect_unexpected: got pc %h expected no redirect at %0t", redirect_pc, $time);
      end else chk("redirect_pc", redirect_pc, rq.pop_front());
    end
  end

  task automatic cyc(input logic r, input logic [3:0] req, input logic bv, input logic pt,
                     input logic rt, input logic [31:0] tgt, input logic [31:0] pc,
                     input logic [5:0] es, input logic ef, input logic erv);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    ex_branch_valid = bv;
    ex_prdt_taken = pt;
    ex_real_taken = rt;
    ex_branch_target = tgt;
    ex_pc = pc;
    e.rst = r;
    e.stall = es;
    e.flush = ef;
    e.rv = erv;
    q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    cyc(1, 4'b1111, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    cyc(0, 4'b1010, 0, 0, 0, 0, 0, 6'b011111, 0, 0);
    cyc(0, 4'b0010, 0, 0, 0, 0, 0, 6'b000111, 0, 0);
    cyc(0, 4'b0001, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
    cyc(0, 4'b0100, 0, 0, 0, 0, 0, 6'b001111, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    rq.push_back(32'h200);
    cyc(0, 4'b0000, 1, 0, 1, 32'h200, 32'h100, 6'b000000, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 6'b000000, 1, 1);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    rq.push_back(32'h0);
    cyc(0, 4'b0000, 1, 1, 0, 32'h1234, 32'hFFFFFFFC, 6'b000000, 0, 0);
    cyc(0, 4'b0010, 1, 0, 1, 32'hDEAD, 32'h0, 6'b000000, 1, 1);
    cyc(0, 4'b0001, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
    cyc(0, 4'b1000, 1, 0, 1, 32'h300, 32'h10, 6'b011111, 0, 0);
    rq.push_back(32'h300);
    cyc(0, 4'b0000, 1, 0, 1, 32'h300, 32'h10, 6'b000000, 0, 0);
    cyc(0, 4'b1010, 0, 0, 0, 0, 0, 6'b011111, 1, 1);
    cyc(0, 4'b1000, 0, 0, 0, 0, 0, 6'b011111, 0, 1);
    cyc(0, 4'b1000, 0, 0, 0, 0, 0, 6'b011111, 0, 1);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 6'b000000, 0, 1);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    rq.push_back(32'h400);
    cyc(0, 4'b0000, 1, 0, 1, 32'h400, 32'h50, 6'b000000, 0, 0);
    cyc(0, 4'b1000, 0, 0, 0, 0, 0, 6'b011111, 1, 1);
    cyc(0, 4'b1000, 0, 0, 0, 0, 0, 6'b011111, 0, 1);
    cyc(1, 4'b1000, 0, 0, 0, 0, 0, 6'b000000, 0, 1);
    void'(rq.pop_back());
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    cyc(0, 4'b0000, 1, 1, 1, 32'h500, 32'h60, 6'b000000, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    @(negedge clk);
    #1;
    chk("expect_queue_drained", q.size(), 0);
    chk("redirects_consumed", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
